// File: rtl/sp_mem_arb_pkg.sv
// Shared types and constants for the two-port single-port-SRAM arbiter.
//   N_PORTS      : number of requesters (fixed at 2)
//   port_idx_t   : index of a requester port
//   mem_req_t    : one request payload at the default widths
package sp_mem_arb_pkg;

    localparam int unsigned N_PORTS            = 2;
    localparam int unsigned MEM_ADDR_WIDTH_DEF = 10;
    localparam int unsigned DATA_WIDTH_DEF     = 64;
    localparam int unsigned BE_WIDTH_DEF       = DATA_WIDTH_DEF / 8;

    typedef logic port_idx_t;

    typedef struct packed {
        logic [MEM_ADDR_WIDTH_DEF-1:0] addr;
        logic                          we;
        logic [BE_WIDTH_DEF-1:0]       be;
        logic [DATA_WIDTH_DEF-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/sp_mem_arb_sel.sv
// Combinational winner select for the two-port memory arbiter.
// Ports:
//   req_i        : per-port request
//   owner_lock_i : lock request of the last-granted port
//   lock_cnt_i   : consecutive locked beats taken by the last-granted port
//   last_i       : last-granted port
//   valid_o      : some port wins this cycle
//   win_o        : winning port (meaningful when valid_o)
// Build option: SP_MEM_ARB_RR_EN selects round-robin for unlocked contention;
// otherwise port 0 has fixed priority.
module sp_mem_arb_sel
    import sp_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_LOCK_BEATS = 8,
    parameter int unsigned CNT_W          = $clog2(MAX_LOCK_BEATS + 1)
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic               owner_lock_i,
    input  logic [CNT_W-1:0]   lock_cnt_i,
    input  port_idx_t          last_i,
    output logic               valid_o,
    output port_idx_t          win_o
);

    logic w_lock_open;

    assign w_lock_open = (lock_cnt_i < CNT_W'(MAX_LOCK_BEATS));

    always_comb begin
        valid_o = |req_i;
        win_o   = 1'b0;
        unique case (req_i)
            2'b01: win_o = 1'b0;
            2'b10: win_o = 1'b1;
            2'b11: begin
                if (owner_lock_i) begin
                    // Owner keeps the memory until its budget runs out, then
                    // the waiting port is guaranteed the next beat.
                    win_o = w_lock_open ? last_i : ~last_i;
                end else begin
`ifdef SP_MEM_ARB_RR_EN
                    win_o = ~last_i;
`else
                    win_o = 1'b0;
`endif
                end
            end
            default: win_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sp_mem_arbiter.sv
// Two-requester arbiter in front of one single-port SRAM (1-cycle read latency).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   req_i/lock_i              : per-port request and burst-lock request
//   addr_i/we_i/be_i/wdata_i  : per-port request payload
//   gnt_o                     : per-port grant (combinational)
//   rvalid_o, rdata_o         : per-port response valid, shared read data
//   mem_*                     : memory-side interface
// Build option: SP_MEM_ARB_RR_EN (see sp_mem_arb_sel) picks round-robin
// instead of port-0 fixed priority for unlocked contention.
module sp_mem_arbiter
    import sp_mem_arb_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned MAX_LOCK_BEATS = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [N_PORTS-1:0]                      req_i,
    input  logic [N_PORTS-1:0]                      lock_i,
    input  logic [N_PORTS-1:0][MEM_ADDR_WIDTH-1:0]  addr_i,
    input  logic [N_PORTS-1:0]                      we_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]    be_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]      wdata_i,
    output logic [N_PORTS-1:0]                      gnt_o,
    output logic [N_PORTS-1:0]                      rvalid_o,
    output logic [DATA_WIDTH-1:0]                   rdata_o,
    output logic                                    mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0]               mem_addr_o,
    output logic                                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                 mem_be_o,
    output logic [DATA_WIDTH-1:0]                   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]                   mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK_BEATS + 1);

    port_idx_t            r_last_q;
    logic [CNT_W-1:0]     r_lock_cnt_q;
    logic [CNT_W-1:0]     w_lock_cnt_d;
    logic [N_PORTS-1:0]   r_rvalid_q;
    logic                 w_any;
    logic                 w_grant;
    port_idx_t            w_win;

    sp_mem_arb_sel #(
        .MAX_LOCK_BEATS (MAX_LOCK_BEATS),
        .CNT_W          (CNT_W)
    ) u_sel (
        .req_i        (req_i),
        .owner_lock_i (lock_i[r_last_q]),
        .lock_cnt_i   (r_lock_cnt_q),
        .last_i       (r_last_q),
        .valid_o      (w_any),
        .win_o        (w_win)
    );

    // Reset is asynchronous, so the combinational grant path is gated too.
    assign w_grant = w_any & ~rst;

    always_comb begin
        gnt_o       = '0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (w_grant) begin
            gnt_o[w_win] = 1'b1;
            mem_req_o    = 1'b1;
            mem_addr_o   = addr_i[w_win];
            mem_we_o     = we_i[w_win];
            mem_be_o     = be_i[w_win];
            mem_wdata_o  = wdata_i[w_win];
        end
    end

    always_comb begin
        w_lock_cnt_d = '0;
        if (w_grant && lock_i[w_win]) begin
            if (w_win == r_last_q) begin
                w_lock_cnt_d = (r_lock_cnt_q < CNT_W'(MAX_LOCK_BEATS)) ?
                               r_lock_cnt_q + CNT_W'(1) : r_lock_cnt_q;
            end else begin
                w_lock_cnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_q     <= 1'b1;
            r_lock_cnt_q <= '0;
            r_rvalid_q   <= '0;
        end else begin
            r_rvalid_q   <= gnt_o;
            r_lock_cnt_q <= w_lock_cnt_d;
            if (w_grant) begin
                r_last_q <= w_win;
            end
        end
    end

    assign rvalid_o = r_rvalid_q;
    assign rdata_o  = mem_rdata_i;

endmodule
